// File: rtl/wb_pipe_stage.sv
// Registered Wishbone pipeline stage with a one-entry skid buffer (IDLE/OUT/FULL).
// Optional macro WB_PIPE_STAGE_RETURN_REG_EN registers the ack/err/data return path.
module wb_pipe_stage #(
  parameter int AW = 30,
  parameter int DW = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wb_gbl_cyc,
  input  logic            i_wb_lcl_cyc,
  input  logic            i_wb_gbl_stb,
  input  logic            i_wb_lcl_stb,
  input  logic            i_wb_we,
  input  logic [AW-1:0]   i_wb_addr,
  input  logic [DW-1:0]   i_wb_data,
  input  logic [DW/8-1:0] i_wb_sel,
  output logic            o_wb_stall,
  output logic            o_wb_ack,
  output logic [DW-1:0]   o_wb_data,
  output logic            o_wb_err,
  output logic            o_dly_gbl_cyc,
  output logic            o_dly_lcl_cyc,
  output logic            o_dly_gbl_stb,
  output logic            o_dly_lcl_stb,
  output logic            o_dly_we,
  output logic [AW-1:0]   o_dly_addr,
  output logic [DW-1:0]   o_dly_data,
  output logic [DW/8-1:0] o_dly_sel,
  input  logic            i_dly_stall,
  input  logic            i_dly_ack,
  input  logic [DW-1:0]   i_dly_data,
  input  logic            i_dly_err,
  output logic [1:0]      o_dbg_state
);

  localparam int SW = DW / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OUT  = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   gbl_cyc_q, gbl_cyc_d, lcl_cyc_q, lcl_cyc_d;

  logic          out_gbl_q, out_we_q;
  logic [AW-1:0] out_addr_q;
  logic [DW-1:0] out_data_q;
  logic [SW-1:0] out_sel_q;
  logic          skid_gbl_q, skid_we_q;
  logic [AW-1:0] skid_addr_q;
  logic [DW-1:0] skid_data_q;
  logic [SW-1:0] skid_sel_q;

  logic up_cyc, dly_cyc, out_valid, up_acc, dn_acc, abort, err_evt;
  logic load_in, load_from_skid, load_skid;
  logic ack_raw, err_raw;

  // Handshake: a request moves on a side whenever its stb is high and that side's stall is low.
  assign up_cyc    = i_wb_gbl_cyc | i_wb_lcl_cyc;
  assign dly_cyc   = gbl_cyc_q | lcl_cyc_q;
  assign out_valid = (state_q != ST_IDLE);
  assign up_acc    = (i_wb_gbl_stb | i_wb_lcl_stb) & ~o_wb_stall;
  assign dn_acc    = out_valid & ~i_dly_stall;
  assign abort     = ~up_cyc;
  assign err_evt   = i_dly_err & dly_cyc;

  always_comb begin
    state_d        = state_q;
    load_in        = 1'b0;
    load_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (abort || err_evt) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (up_acc) begin
            state_d = ST_OUT;
            load_in = 1'b1;
          end
        end
        ST_OUT: begin
          if (dn_acc && up_acc) begin
            load_in = 1'b1;
          end else if (dn_acc) begin
            state_d = ST_IDLE;
          end else if (up_acc) begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
          end
        end
        ST_FULL: begin
          if (dn_acc) begin
            state_d        = ST_OUT;
            load_from_skid = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A downstream cyc only rises alongside a strobe; it falls after an upstream drop or an error.
  assign gbl_cyc_d = ~err_evt & i_wb_gbl_cyc & (gbl_cyc_q | i_wb_gbl_stb);
  assign lcl_cyc_d = ~err_evt & i_wb_lcl_cyc & (lcl_cyc_q | i_wb_lcl_stb);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      gbl_cyc_q <= 1'b0;
      lcl_cyc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gbl_cyc_q <= gbl_cyc_d;
      lcl_cyc_q <= lcl_cyc_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (load_in) begin
      out_gbl_q  <= i_wb_gbl_stb;
      out_we_q   <= i_wb_we;
      out_addr_q <= i_wb_addr;
      out_data_q <= i_wb_data;
      out_sel_q  <= i_wb_sel;
    end else if (load_from_skid) begin
      out_gbl_q  <= skid_gbl_q;
      out_we_q   <= skid_we_q;
      out_addr_q <= skid_addr_q;
      out_data_q <= skid_data_q;
      out_sel_q  <= skid_sel_q;
    end
    if (load_skid) begin
      skid_gbl_q  <= i_wb_gbl_stb;
      skid_we_q   <= i_wb_we;
      skid_addr_q <= i_wb_addr;
      skid_data_q <= i_wb_data;
      skid_sel_q  <= i_wb_sel;
    end
  end

  assign o_wb_stall    = (state_q == ST_FULL);
  assign o_dly_gbl_cyc = gbl_cyc_q;
  assign o_dly_lcl_cyc = lcl_cyc_q;
  assign o_dly_gbl_stb = out_valid & out_gbl_q;
  assign o_dly_lcl_stb = out_valid & ~out_gbl_q;
  assign o_dly_we      = out_we_q;
  assign o_dly_addr    = out_addr_q;
  assign o_dly_data    = out_data_q;
  assign o_dly_sel     = out_sel_q;
  assign o_dbg_state   = state_q;

  // Responses only pass while both sides hold cyc; an ack alongside an err is dropped.
  assign ack_raw = i_dly_ack & ~i_dly_err & dly_cyc & up_cyc;
  assign err_raw = i_dly_err & dly_cyc & up_cyc;

`ifdef WB_PIPE_STAGE_RETURN_REG_EN
  logic          ack_q, err_q;
  logic [DW-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= ack_raw;
      err_q <= err_raw;
    end
  end

  always_ff @(posedge i_clk) begin
    rdata_q <= i_dly_data;
  end

  assign o_wb_ack  = ack_q & up_cyc;
  assign o_wb_err  = err_q & up_cyc;
  assign o_wb_data = rdata_q;
`else
  assign o_wb_ack  = ack_raw;
  assign o_wb_err  = err_raw;
  assign o_wb_data = i_dly_data;
`endif

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Bench for wb_pipe_stage: directed scenarios plus random traffic, downstream order scoreboard.
// Return-path latency follows WB_PIPE_STAGE_RETURN_REG_EN.
module tb_wb_pipe_stage;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int EW = 2 + AW + DW + SW;
`ifdef WB_PIPE_STAGE_RETURN_REG_EN
  localparam int RL = 1;
`else
  localparam int RL = 0;
`endif

  typedef logic [EW-1:0] val_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          gbl_cyc, lcl_cyc, gbl_stb, lcl_stb, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] sel;
  logic          wb_stall, wb_ack, wb_err;
  logic [DW-1:0] wb_rdata;
  logic          dly_gbl_cyc, dly_lcl_cyc, dly_gbl_stb, dly_lcl_stb, dly_we;
  logic [AW-1:0] dly_addr;
  logic [DW-1:0] dly_wdata;
  logic [SW-1:0] dly_sel;
  logic          dly_stall, dly_ack, dly_err;
  logic [DW-1:0] dly_rdata;
  logic [1:0]    dbg_state;

  wb_pipe_stage #(.AW(AW), .DW(DW)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_wb_gbl_cyc(gbl_cyc), .i_wb_lcl_cyc(lcl_cyc),
    .i_wb_gbl_stb(gbl_stb), .i_wb_lcl_stb(lcl_stb),
    .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
    .o_wb_stall(wb_stall), .o_wb_ack(wb_ack), .o_wb_data(wb_rdata), .o_wb_err(wb_err),
    .o_dly_gbl_cyc(dly_gbl_cyc), .o_dly_lcl_cyc(dly_lcl_cyc),
    .o_dly_gbl_stb(dly_gbl_stb), .o_dly_lcl_stb(dly_lcl_stb),
    .o_dly_we(dly_we), .o_dly_addr(dly_addr), .o_dly_data(dly_wdata), .o_dly_sel(dly_sel),
    .i_dly_stall(dly_stall), .i_dly_ack(dly_ack), .i_dly_data(dly_rdata), .i_dly_err(dly_err),
    .o_dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   err_seen = 0;
  val_t exp_q[$];
  val_t mon_got;

  task automatic check(input string tag, input val_t act, input val_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", tag, act, exp);
    end
  endtask

  function automatic val_t ctrl();
    return val_t'({dly_gbl_cyc, dly_lcl_cyc, dly_gbl_stb, dly_lcl_stb, wb_stall, wb_ack, wb_err});
  endfunction

  // Scoreboard: push accepted upstream requests, pop on downstream accept; abort/err/reset flush.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if ((dly_gbl_stb || dly_lcl_stb) && !dly_stall) begin
        mon_got = {dly_gbl_stb, dly_we, dly_addr, dly_wdata, dly_sel};
        if (exp_q.size() == 0) check("dn_unexpected", mon_got, '1);
        else check("dn_order", mon_got, exp_q.pop_front());
      end
      if ((gbl_cyc || lcl_cyc) && (gbl_stb || lcl_stb) && !wb_stall)
        exp_q.push_back({gbl_stb, we, addr, wdata, sel});
      if (!(gbl_cyc || lcl_cyc) || dly_err) exp_q.delete();
    end
    if (wb_err) err_seen++;
  end

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit g, input bit w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
    gbl_cyc = g;  lcl_cyc = !g;
    gbl_stb = g;  lcl_stb = !g;
    we = w; addr = a; wdata = d; sel = s;
  endtask

  task automatic hold_cyc();
    gbl_stb = 1'b0;
    lcl_stb = 1'b0;
  endtask

  task automatic release_bus();
    gbl_cyc = 1'b0; lcl_cyc = 1'b0; gbl_stb = 1'b0; lcl_stb = 1'b0;
    dly_ack = 1'b0; dly_err = 1'b0; dly_stall = 1'b0;
  endtask

  task automatic fill_skid(input logic [AW-1:0] base);
    next_cycle();
    dly_stall = 1'b1;
    drive_req(1'b1, 1'b1, base, 32'hA000_0000 | 32'(base), 4'hF);
    next_cycle();
    drive_req(1'b1, 1'b1, base + 1, 32'hB000_0000 | 32'(base), 4'h3);
    @(negedge clk);
    check("fill_no_stall", val_t'(wb_stall), 0);
  endtask

  initial begin
    bit   have;
    int   idx, sent, guard;
    logic [7:0] stall_tab, dstall_tab;
    logic r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic [SW-1:0] r_sel;

    rst = 1'b1;
    release_bus();
    we = 1'b0; addr = '0; wdata = '0; sel = '0; dly_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", ctrl(), 0);
    check("reset_state", val_t'(dbg_state), 0);
    next_cycle();
    rst = 1'b0;

    // Single read
    next_cycle();
    drive_req(1'b1, 1'b0, 30'h100, 32'h0, 4'hF);
    next_cycle();
    hold_cyc();
    @(negedge clk);
    check("rd_ctrl", ctrl(), val_t'(7'b1010000));
    check("rd_addr", val_t'(dly_addr), val_t'(30'h100));
    next_cycle();
    dly_ack = 1'b1; dly_rdata = 32'hDEAD_BEEF;
    repeat (RL) begin next_cycle(); dly_ack = 1'b0; dly_rdata = 32'h0; end
    @(negedge clk);
    check("rd_ack", val_t'(wb_ack), 1);
    check("rd_data", val_t'(wb_rdata), val_t'(32'hDEAD_BEEF));
    next_cycle();
    dly_ack = 1'b0; dly_rdata = 32'h0;
    @(negedge clk);
    check("rd_ack_low", val_t'(wb_ack), 0);

    // Ack in the same cycle as upstream cyc drop is suppressed
    next_cycle();
    drive_req(1'b1, 1'b0, 30'h104, 32'h0, 4'hF);
    next_cycle();
    hold_cyc();
    next_cycle();
    gbl_cyc = 1'b0; dly_ack = 1'b1;
    @(negedge clk);
    check("drop_ack_same", val_t'(wb_ack), 0);
    next_cycle();
    dly_ack = 1'b0;
    @(negedge clk);
    check("drop_ack_next", val_t'(wb_ack), 0);
    check("drop_cyc_clear", ctrl(), 0);

    // Burst of 4 writes with downstream stall during cycles 2-3
    stall_tab  = 8'b0001_1000;
    dstall_tab = 8'b0000_1100;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      dly_stall = dstall_tab[c];
      if (idx < 4) drive_req(1'b1, 1'b1, 30'h10 + 30'(idx), $urandom, 4'($urandom_range(1, 15)));
      else hold_cyc();
      @(negedge clk);
      check($sformatf("burst_stall_c%0d", c), val_t'(wb_stall), val_t'(stall_tab[c]));
      if (idx < 4 && !wb_stall) idx++;
    end
    check("burst_sent", val_t'(idx), 4);
    check("burst_drained", val_t'(exp_q.size()), 0);
    next_cycle();
    release_bus();

    // Abort while FULL; a later ack must not be forwarded
    fill_skid(30'h20);
    next_cycle();
    @(negedge clk);
    check("abort_full", val_t'(wb_stall), 1);
    next_cycle();
    release_bus();
    dly_stall = 1'b1;
    @(negedge clk);
    next_cycle();
    dly_stall = 1'b0; dly_ack = 1'b1;
    @(negedge clk);
    check("abort_ctrl", ctrl(), 0);
    check("abort_state", val_t'(dbg_state), 0);
    next_cycle();
    dly_ack = 1'b0;
    @(negedge clk);
    check("abort_late_ack", val_t'(wb_ack), 0);
    repeat (3) next_cycle();

    // Error during a 3-request burst
    err_seen = 0;
    fill_skid(30'h30);
    next_cycle();
    drive_req(1'b1, 1'b1, 30'h32, 32'hC0C0_C0C0, 4'hF);
    dly_err = 1'b1; dly_ack = 1'b1;
    @(negedge clk);
    check("err_in_full", val_t'(wb_stall), 1);
    check("err_ack_ignored", val_t'(wb_ack), 0);
    next_cycle();
    hold_cyc();
    dly_err = 1'b0; dly_ack = 1'b0; dly_stall = 1'b0;
    @(negedge clk);
    check("err_cyc_clear", val_t'({dly_gbl_cyc, dly_gbl_stb, wb_stall}), 0);
    repeat (4) next_cycle();
    @(negedge clk);
    check("err_once", val_t'(err_seen), 1);
    next_cycle();
    release_bus();

    // Local bus read at top address
    next_cycle();
    drive_req(1'b0, 1'b0, 30'h3FFF_FFFF, 32'h0, 4'hF);
    next_cycle();
    hold_cyc();
    @(negedge clk);
    check("lcl_ctrl", ctrl(), val_t'(7'b0101000));
    check("lcl_addr", val_t'(dly_addr), val_t'(30'h3FFF_FFFF));
    next_cycle();
    dly_ack = 1'b1; dly_rdata = 32'h1234_5678;
    repeat (RL) begin next_cycle(); dly_ack = 1'b0; dly_rdata = 32'h0; end
    @(negedge clk);
    check("lcl_ack", val_t'({wb_ack, dly_gbl_cyc, dly_gbl_stb}), val_t'(3'b100));
    check("lcl_data", val_t'(wb_rdata), val_t'(32'h1234_5678));
    next_cycle();
    release_bus();

    // Reset while FULL
    fill_skid(30'h40);
    next_cycle();
    hold_cyc();
    rst = 1'b1;
    @(negedge clk);
    check("rst_pre_full", val_t'(wb_stall), 1);
    next_cycle();
    rst = 1'b0; dly_stall = 1'b0;
    @(negedge clk);
    check("rst_ctrl", ctrl(), 0);
    check("rst_state", val_t'(dbg_state), 0);
    next_cycle();
    drive_req(1'b1, 1'b0, 30'h44, 32'h4444_4444, 4'h1);
    next_cycle();
    hold_cyc();
    @(negedge clk);
    check("rst_new_addr", val_t'(dly_addr), val_t'(30'h44));
    next_cycle();
    @(negedge clk);
    check("rst_skid_empty", val_t'({exp_q.size() == 0, dly_gbl_stb}), val_t'(2'b10));
    next_cycle();
    release_bus();

    // Random traffic with random downstream stall
    sent = 0; guard = 0; have = 1'b0;
    r_we = 1'b0; r_addr = '0; r_data = '0; r_sel = '0;
    while (sent < 30 && guard < 600) begin
      next_cycle();
      if (!have && $urandom_range(0, 3) != 0) begin
        have = 1'b1;
        r_we = 1'($urandom_range(0, 1));
        r_addr = 30'($urandom);
        r_data = $urandom;
        r_sel = 4'($urandom_range(0, 15));
      end
      if (have) drive_req(1'b1, r_we, r_addr, r_data, r_sel);
      else begin gbl_cyc = 1'b1; hold_cyc(); end
      dly_stall = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      if (have && !wb_stall) begin have = 1'b0; sent++; end
      guard++;
    end
    check("rand_sent", val_t'(sent), 30);
    next_cycle();
    hold_cyc(); dly_stall = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    check("rand_drained", val_t'(exp_q.size()), 0);
    next_cycle();
    release_bus();
    repeat (2) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: actual running required finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
